fifo_stream_reader: RTL and testbench

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader.sv | 93 +++++++++
 tb/tb_fifo_stream_reader.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Pops words from an upstream FIFO into a two-entry in-order buffer and
// presents them as a valid/ready stream grouped into fixed-length bursts.
// m_last flags the final beat of each burst, and burst_done pulses for one
// cycle after that beat is accepted.

module fifo_stream_reader #(
    parameter int DW        = 8,
    parameter int BURST_LEN = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          enable,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_data,
    input  logic          wr_active,
    output logic          fifo_pop,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    input  logic          m_ready,
    output logic          burst_done
);

    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

    logic [DW-1:0] head_q;
    logic [DW-1:0] tail_q;
    logic [1:0]    occ;
    logic [7:0]    beat_cnt;
    logic          handshake;

    // Pop only when there is room and the upstream FIFO is safe to read.
    assign fifo_pop  = rstn && enable && !fifo_empty && !wr_active && (occ != 2'd2);
    assign m_valid   = (occ != 2'd0);
    assign m_data    = head_q;
    assign handshake = m_valid && m_ready;
    assign m_last    = m_valid && (beat_cnt == LAST_BEAT);

    // Two-entry buffer: the head feeds the output, and new words go to the first free slot.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            occ    <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            case ({fifo_pop, handshake})
                2'b10: begin
                    if (occ == 2'd0) head_q <= fifo_data;
                    else             tail_q <= fifo_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    occ    <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head_q <= fifo_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= fifo_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Beat position within the current burst; it survives enable going low.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            beat_cnt <= 8'd0;
        end else if (handshake) begin
            if (beat_cnt == LAST_BEAT) beat_cnt <= 8'd0;
            else                       beat_cnt <= beat_cnt + 8'd1;
        end
    end

    // One-cycle pulse after the last beat of a burst is accepted.
    always_ff @(posedge clk) begin
        if (!rstn) burst_done <= 1'b0;
        else       burst_done <= handshake && m_last;
    end

    // Safety properties of the upstream and downstream interfaces.
    a_no_pop_empty: assert property (@(posedge clk) !(fifo_pop && fifo_empty));
    a_no_pop_write: assert property (@(posedge clk) !(fifo_pop && wr_active));
    a_occ_range:    assert property (@(posedge clk) occ != 2'd3);
    a_stall_stable: assert property (@(posedge clk)
                                     (rstn && m_valid && !m_ready) |=> $stable(m_data));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader
// Randomized and directed stimulus for fifo_stream_reader, checked against
// a queue-based model of the upstream FIFO and the output stream.

module tb_fifo_stream_reader;

    localparam int DW = 8;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          enable;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          wr_active;
    logic          fifo_pop;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready;
    logic          burst_done;

    logic [DW-1:0] src_q[$];
    logic [DW-1:0] out_q[$];
    int            beats;
    logic          exp_done;
    int            vecCount = 0;
    int            errCount = 0;

    fifo_stream_reader #(.DW(DW), .BURST_LEN(BL)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .wr_active  (wr_active),
        .fifo_pop   (fifo_pop),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .burst_done (burst_done)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs at negedge, compare, then advance the model at posedge.
    task automatic applyStimulus(input logic en, input logic wr, input logic rdy, input logic rs);
        logic exp_pop, exp_valid, exp_last, hs;
        @(negedge clk);
        rstn       = rs;
        enable     = en;
        wr_active  = wr;
        m_ready    = rdy;
        fifo_empty = (src_q.size() == 0);
        fifo_data  = (src_q.size() != 0) ? src_q[0] : '0;
        #1;
        exp_pop   = rs && en && (src_q.size() != 0) && !wr && (out_q.size() < 2);
        exp_valid = (out_q.size() != 0);
        exp_last  = exp_valid && ((beats % BL) == BL - 1);
        checkOutput("fifo_pop", 32'(fifo_pop), 32'(exp_pop));
        checkOutput("m_valid", 32'(m_valid), 32'(exp_valid));
        checkOutput("m_last", 32'(m_last), 32'(exp_last));
        checkOutput("burst_done", 32'(burst_done), 32'(exp_done));
        if (exp_valid) checkOutput("m_data", 32'(m_data), 32'(out_q[0]));
        @(posedge clk);
        if (!rs) begin
            out_q.delete();
            beats    = 0;
            exp_done = 1'b0;
        end else begin
            hs       = exp_valid && rdy;
            exp_done = hs && exp_last;
            if (hs) begin
                void'(out_q.pop_front());
                beats++;
            end
            if (exp_pop) out_q.push_back(src_q.pop_front());
        end
        if (wr && (src_q.size() < 16) && ($urandom_range(0, 1) == 1))
            src_q.push_back(DW'($urandom));
    endtask

    task automatic runCycles(input int n, input logic en, input logic wr, input logic rdy);
        for (int i = 0; i < n; i++) applyStimulus(en, wr, rdy, 1'b1);
    endtask

    task automatic preload(input logic [DW-1:0] first, input int n);
        for (int i = 0; i < n; i++) src_q.push_back(first + DW'(i));
    endtask

    // Stimulus sequence: reset, directed scenarios, then a random soak.
    initial begin
        rstn       = 1'b0;
        enable     = 1'b0;
        wr_active  = 1'b0;
        m_ready    = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        beats      = 0;
        exp_done   = 1'b0;

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        #1 checkOutput("m_data_reset", 32'(m_data), 32'h0);

        // Streaming burst 0x11..0x18 at full rate.
        preload(8'h11, 8);
        runCycles(12, 1'b1, 1'b0, 1'b1);

        // Stall with three words queued: only two pops, then ordered drain.
        preload(8'hA0, 3);
        runCycles(5, 1'b1, 1'b0, 1'b0);
        #1 checkOutput("stall_src_left", 32'(src_q.size()), 32'd1);
        runCycles(5, 1'b1, 1'b0, 1'b1);

        // Upstream write pulses on alternate cycles.
        preload(8'h30, 8);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'(i % 2), 1'b1, 1'b1);

        // Enable dropped mid-burst, then restored.
        preload(8'h50, 8);
        runCycles(3, 1'b1, 1'b0, 1'b1);
        runCycles(4, 1'b0, 1'b0, 1'b1);
        runCycles(8, 1'b1, 1'b0, 1'b1);

        // Reset with a full buffer and a partly counted burst.
        preload(8'h70, 8);
        runCycles(3, 1'b1, 1'b0, 1'b1);
        runCycles(2, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        runCycles(10, 1'b1, 1'b0, 1'b1);

        // Random soak.
        for (int i = 0; i < 800; i++)
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 3),
                          1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 49) != 0));

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
